// File: rtl/rgb_pkg.sv
// Shared definitions for the RGB stream gearbox and its position counter.
package rgb_pkg;

   localparam int PIX_W          = 24;
   localparam int WORD_W         = 64;
   localparam int BYTES_PER_WORD = 8;
   localparam int BYTES_PER_PIX  = 3;
   localparam int BUF_BYTES      = 10;
   localparam int BUF_W          = BUF_BYTES * 8;
   localparam int LEVEL_W        = $clog2(BUF_BYTES + 1);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Width of an index that ranges over 0..n-1.
   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // Width of a counter that ranges over 0..n inclusive.
   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/rgb_stream_unpacker_pos.sv
// Raster position tracker: x/y counters that step on each accepted pixel,
// with first-pixel, end-of-line and last-pixel-of-frame flags.
module rgb_pos_counter
   import rgb_pkg::*;
#(
   parameter int H_RES = 1280,
   parameter int V_RES = 720,
   parameter int X_W   = idx_w(H_RES),
   parameter int Y_W   = idx_w(V_RES)
) (
   input  logic i_clk,
   input  logic i_srst,
   input  logic i_clr,
   input  logic i_adv,
   output logic o_sof,
   output logic o_eol,
   output logic o_last
);

   logic [X_W-1:0] r_x;
   logic [Y_W-1:0] r_y;
   logic           w_x_end;
   logic           w_y_end;

   assign w_x_end = (r_x == X_W'(H_RES - 1));
   assign w_y_end = (r_y == Y_W'(V_RES - 1));

   assign o_sof  = (r_x == '0) && (r_y == '0);
   assign o_eol  = w_x_end;
   assign o_last = w_x_end && w_y_end;

   // Advance along the raster; x wraps into y, y wraps at the frame end.
   always_ff @(posedge i_clk) begin
      if (i_srst || i_clr) begin
         r_x <= '0;
         r_y <= '0;
      end else if (i_adv) begin
         if (w_x_end) begin
            r_x <= '0;
            r_y <= w_y_end ? '0 : r_y + Y_W'(1);
         end else begin
            r_x <= r_x + X_W'(1);
         end
      end
   end

endmodule

// File: rtl/rgb_stream_unpacker.sv
// Gearbox from 64-bit memory words to 24-bit {B,G,R} pixels, one frame
// per start pulse, with exact stop at the frame's last word.
module rgb_stream_unpacker
   import rgb_pkg::*;
#(
   parameter int H_RES = 1280,
   parameter int V_RES = 720
) (
   input  logic                m_axi_acp_aclk,
   input  logic                axi_reset,
   input  logic                start,
   output logic                busy,
   output logic                frame_done,
   input  logic [WORD_W-1:0]   mm2s_data,
   input  logic                mm2s_valid,
   output logic                mm2s_ready,
   output logic [PIX_W-1:0]    pix_data,
   output logic                pix_valid,
   input  logic                pix_ready,
   output logic                pix_sof,
   output logic                pix_eol
);

   localparam int FRAME_WORDS = H_RES * V_RES * BYTES_PER_PIX / BYTES_PER_WORD;
   localparam int WC_W        = cnt_w(FRAME_WORDS);

   state_t               r_state;
   state_t               w_state_next;
   logic [LEVEL_W-1:0]   r_level;
   logic [LEVEL_W-1:0]   w_level_next;
   logic [LEVEL_W-1:0]   w_wr_base;
   logic [BUF_W-1:0]     r_buf;
   logic [BUF_W-1:0]     w_buf_next;
   logic [BUF_W-1:0]     w_shifted;
   logic [WC_W-1:0]      r_words_rx;
   logic                 r_frame_done;

   logic w_run;
   logic w_pix_valid;
   logic w_pop;
   logic w_push;
   logic w_room;
   logic w_mm2s_ready;
   logic w_start_acc;
   logic w_sof;
   logic w_eol;
   logic w_last;

   assign w_run        = (r_state == RUN);
   assign w_pix_valid  = w_run && (r_level >= LEVEL_W'(BYTES_PER_PIX));
   assign w_pop        = w_pix_valid && pix_ready;
   // Room for a full word either now, or once this cycle's pixel leaves.
   assign w_room       = (r_level <= LEVEL_W'(2)) ||
                         ((r_level <= LEVEL_W'(5)) && w_pop);
   assign w_mm2s_ready = w_run && (r_words_rx < WC_W'(FRAME_WORDS)) && w_room;
   assign w_push       = mm2s_valid && w_mm2s_ready;
   assign w_start_acc  = !w_run && start;

   assign w_shifted    = w_pop ? (r_buf >> PIX_W) : r_buf;
   assign w_wr_base    = r_level - (w_pop ? LEVEL_W'(BYTES_PER_PIX) : '0);
   assign w_level_next = w_wr_base + (w_push ? LEVEL_W'(BYTES_PER_WORD) : '0);

   // Each buffer byte takes either the shifted old content or one lane of
   // the incoming word; a negative offset wraps high and never hits.
   for (genvar gi = 0; gi < BUF_BYTES; gi++) begin : g_byte
      logic [LEVEL_W-1:0] w_rel;
      logic               w_hit;
      assign w_rel = LEVEL_W'(gi) - w_wr_base;
      assign w_hit = w_push && (w_rel < LEVEL_W'(BYTES_PER_WORD));
      assign w_buf_next[gi*8 +: 8] = w_hit ? mm2s_data[{w_rel[2:0], 3'b000} +: 8]
                                           : w_shifted[gi*8 +: 8];
   end

   rgb_pos_counter #(
      .H_RES (H_RES),
      .V_RES (V_RES)
   ) u_pos (
      .i_clk  (m_axi_acp_aclk),
      .i_srst (axi_reset),
      .i_clr  (w_start_acc),
      .i_adv  (w_pop),
      .o_sof  (w_sof),
      .o_eol  (w_eol),
      .o_last (w_last)
   );

   // Next-state: arm on start, return to idle when the final pixel leaves.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (start) w_state_next = RUN;
         RUN:     if (w_pop && w_last) w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge m_axi_acp_aclk) begin
      if (axi_reset) r_state <= IDLE;
      else           r_state <= w_state_next;
   end

   // Gearbox buffer, fill level, word count and completion pulse.
   always_ff @(posedge m_axi_acp_aclk) begin
      if (axi_reset) begin
         r_buf        <= '0;
         r_level      <= '0;
         r_words_rx   <= '0;
         r_frame_done <= 1'b0;
      end else begin
         r_buf        <= w_buf_next;
         r_level      <= w_level_next;
         r_frame_done <= w_run && w_pop && w_last;
         if (w_start_acc)
            r_words_rx <= '0;
         else if (w_push)
            r_words_rx <= r_words_rx + WC_W'(1);
      end
   end

   assign busy       = w_run;
   assign frame_done = r_frame_done;
   assign mm2s_ready = w_mm2s_ready;
   assign pix_valid  = w_pix_valid;
   assign pix_data   = r_buf[PIX_W-1:0];
   assign pix_sof    = w_pix_valid && w_sof;
   assign pix_eol    = w_pix_valid && w_eol;

endmodule

// File: tb/tb_rgb_stream_unpacker.sv
// Randomized bench for rgb_stream_unpacker against a byte-stream model.
module tb_rgb_stream_unpacker;

   localparam int H      = 16;
   localparam int V      = 3;
   localparam int NPIX   = H * V;
   localparam int NBYTES = NPIX * 3;
   localparam int FW     = NBYTES / 8;
   localparam int BUDGET = 3000;

   logic        clk = 1'b0;
   logic        axi_reset;
   logic        start;
   logic        busy;
   logic        frame_done;
   logic [63:0] mm2s_data;
   logic        mm2s_valid;
   logic        mm2s_ready;
   logic [23:0] pix_data;
   logic        pix_valid;
   logic        pix_ready;
   logic        pix_sof;
   logic        pix_eol;

   always #5 clk = ~clk;

   rgb_stream_unpacker #(.H_RES(H), .V_RES(V)) dut (
      .m_axi_acp_aclk (clk),
      .axi_reset      (axi_reset),
      .start          (start),
      .busy           (busy),
      .frame_done     (frame_done),
      .mm2s_data      (mm2s_data),
      .mm2s_valid     (mm2s_valid),
      .mm2s_ready     (mm2s_ready),
      .pix_data       (pix_data),
      .pix_valid      (pix_valid),
      .pix_ready      (pix_ready),
      .pix_sof        (pix_sof),
      .pix_eol        (pix_eol)
   );

   logic [7:0] fb [0:NBYTES-1];
   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [63:0] get_word(input int w);
      logic [63:0] r;
      r = 64'hDEAD_BEEF_0BAD_F00D;
      if (w < FW)
         for (int k = 0; k < 8; k++) r[8*k +: 8] = fb[8*w + k];
      return r;
   endfunction

   // ---------------- model state (updated at negedge) ----------------
   bit         m_run = 0, m_done = 0;
   int         m_words = 0, m_pix = 0, frames_done = 0, cyc = 0;
   bit         lit_frame = 0, full_rate = 0;
   int         start_cyc = 0, first_pop_cyc = 0;
   bit         prev_stall = 0;
   logic [23:0] prev_data = '0;
   int         avail;
   bit         exp_valid, exp_pop, exp_ready, push, pop;
   logic [23:0] exp_pix;

   // Compare DUT against the byte-stream model every cycle, then step it.
   always @(negedge clk) begin
      cyc++;
      avail     = 8 * m_words - 3 * m_pix;
      exp_valid = m_run && (avail >= 3);
      exp_pop   = exp_valid && pix_ready;
      exp_ready = m_run && (m_words < FW) && ((avail <= 2) || ((avail <= 5) && exp_pop));
      chk("pix_valid", 64'(pix_valid), 64'(exp_valid));
      chk("mm2s_ready", 64'(mm2s_ready), 64'(exp_ready));
      chk("busy", 64'(busy), 64'(m_run));
      chk("frame_done", 64'(frame_done), 64'(m_done));
      chk("level_max", 64'(dut.r_level <= 10), 64'(1));
      if (m_done) chk("level_residue", 64'(dut.r_level), 64'(0));
      if (prev_stall) begin
         chk("stall_valid", 64'(pix_valid), 64'(1));
         chk("stall_data", 64'(pix_data), 64'(prev_data));
      end
      if (exp_valid && pix_valid) begin
         exp_pix = {fb[3*m_pix+2], fb[3*m_pix+1], fb[3*m_pix]};
         chk("pix_data", 64'(pix_data), 64'(exp_pix));
         chk("pix_sof", 64'(pix_sof), 64'(m_pix == 0));
         chk("pix_eol", 64'(pix_eol), 64'((m_pix % H) == H - 1));
         if (lit_frame && pix_ready) begin
            if (m_pix == 0)        chk("lit_pix0", 64'(pix_data), 64'h020100);
            if (m_pix == 2)        chk("lit_pix2", 64'(pix_data), 64'h080706);
            if (m_pix == NPIX - 1) chk("lit_pixlast", 64'(pix_data), 64'h8F8E8D);
         end
      end
      prev_stall = pix_valid && !pix_ready && !axi_reset;
      prev_data  = pix_data;

      push = mm2s_valid && mm2s_ready;
      pop  = pix_valid && pix_ready;
      if (axi_reset) begin
         m_run = 0; m_done = 0; m_words = 0; m_pix = 0;
      end else begin
         m_done = 0;
         if (m_run) begin
            if (push) m_words++;
            if (pop) begin
               if (m_pix == 0) begin
                  first_pop_cyc = cyc;
                  if (full_rate) chk("first_pix_latency", 64'(cyc - start_cyc), 64'(2));
               end
               if (m_pix == NPIX - 1) begin
                  chk("words_per_frame", 64'(m_words), 64'(FW));
                  if (full_rate) chk("full_rate_span", 64'(cyc - first_pop_cyc), 64'(NPIX - 1));
                  m_run = 0;
                  m_done = 1;
                  frames_done++;
               end
               m_pix++;
            end
         end else if (start) begin
            m_run = 1; m_words = 0; m_pix = 0; start_cyc = cyc;
         end
      end
   end

   // ---------------- driver ----------------
   int wi = 0;

   task automatic step(input int vp, input int rp, input bit st, input bit rst);
      bit acc;
      mm2s_valid = (vp >= 100) ? 1'b1 : ($urandom_range(99) < vp);
      pix_ready  = (rp >= 100) ? 1'b1 : ($urandom_range(99) < rp);
      mm2s_data  = get_word(wi);
      start      = st;
      axi_reset  = rst;
      @(negedge clk);
      acc = mm2s_valid && mm2s_ready;
      @(posedge clk);
      #1;
      if (rst)      wi = 0;
      else if (acc) wi++;
      start     = 1'b0;
      axi_reset = 1'b0;
   endtask

   task automatic run_frame(input int vp, input int rp, input int busy_start_at, input int reset_at);
      int  f0;
      bit  sb_done, rst_done;
      f0 = frames_done;
      sb_done = 0;
      rst_done = 0;
      wi = 0;
      step(vp, rp, 1'b1, 1'b0);
      for (int c = 0; c < BUDGET && frames_done == f0; c++) begin
         if (!sb_done && m_run && m_pix >= busy_start_at) begin
            sb_done = 1;
            step(vp, rp, 1'b1, 1'b0);
         end else if (!rst_done && m_run && m_pix >= reset_at) begin
            rst_done = 1;
            step(vp, rp, 1'b0, 1'b1);
            chk("rst_mm2s_ready", 64'(mm2s_ready), 64'(0));
            chk("rst_pix_valid", 64'(pix_valid), 64'(0));
            chk("rst_busy", 64'(busy), 64'(0));
            return;
         end else begin
            step(vp, rp, 1'b0, 1'b0);
         end
      end
      chk("frame_timeout", 64'(frames_done != f0), 64'(1));
   endtask

   initial begin
      axi_reset  = 1'b1;
      start      = 1'b0;
      mm2s_valid = 1'b0;
      mm2s_data  = '0;
      pix_ready  = 1'b0;
      for (int i = 0; i < NBYTES; i++) fb[i] = 8'(i);
      repeat (3) step(0, 0, 1'b0, 1'b1);
      chk("reset_mm2s_ready", 64'(mm2s_ready), 64'(0));
      chk("reset_pix_valid", 64'(pix_valid), 64'(0));
      chk("reset_pix_sof", 64'(pix_sof), 64'(0));
      chk("reset_pix_eol", 64'(pix_eol), 64'(0));
      chk("reset_busy", 64'(busy), 64'(0));
      chk("reset_frame_done", 64'(frame_done), 64'(0));
      chk("reset_pix_data", 64'(pix_data), 64'(0));
      $display("frame A: ramp bytes, full rate");

      // Frame A: byte ramp, both sides always ready, plus literal pins.
      lit_frame = 1; full_rate = 1;
      run_frame(100, 100, NPIX + 10, NPIX + 10);
      lit_frame = 0; full_rate = 0;
      // Source keeps offering past the frame boundary: nothing is taken.
      for (int i = 0; i < 5; i++) begin
         step(100, 100, 1'b0, 1'b0);
         chk("boundary_ready", 64'(mm2s_ready), 64'(0));
      end
      $display("frame B: random, start pulsed while busy");
      for (int i = 0; i < NBYTES; i++) fb[i] = 8'($urandom);
      run_frame(50, 30, 10, NPIX + 10);

      $display("frame C: random, reset mid-frame");
      for (int i = 0; i < NBYTES; i++) fb[i] = 8'($urandom);
      run_frame(50, 30, NPIX + 10, 20);
      step(50, 30, 1'b1, 1'b1);
      step(50, 30, 1'b0, 1'b0);
      chk("start_with_reset_busy", 64'(busy), 64'(0));

      $display("frame D: random after reset");
      for (int i = 0; i < NBYTES; i++) fb[i] = 8'($urandom);
      run_frame(70, 60, NPIX + 10, NPIX + 10);

      $display("frame E: random data, full rate");
      for (int i = 0; i < NBYTES; i++) fb[i] = 8'($urandom);
      full_rate = 1;
      run_frame(100, 100, NPIX + 10, NPIX + 10);
      full_rate = 0;
      repeat (3) step(0, 100, 1'b0, 1'b0);
      chk("frames_completed", 64'(frames_done), 64'(4));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
